booth_mac_accumulator: RTL

//   Downstream consumer of the Booth-Wallace multiplier in each vector lane.

---
 rtl/booth_mac_accumulator_if.sv | 29 ++
 rtl/booth_mac_accumulator.sv | 101 ++++++++++
 2 files changed

// File: rtl/booth_mac_accumulator_if.sv
// rtl/booth_mac_accumulator_if.sv - control, product and result signals of the MAC accumulator
interface booth_mac_accumulator_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int LEN_WIDTH = 8
);
    logic                   start;
    logic [LEN_WIDTH-1:0]   len;
    logic                   signed_mode;
    logic                   prod_valid;
    logic                   prod_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   res_valid;
    logic                   res_ready;
    logic [ACC_WIDTH-1:0]   result;
    logic                   overflow;
    logic                   busy;

    // master drives the reduction (sequencer/multiplier side), slave is the accumulator
    modport master (
        output start, len, signed_mode, prod_valid, product, res_ready,
        input  prod_ready, res_valid, result, overflow, busy
    );

    modport slave (
        input  start, len, signed_mode, prod_valid, product, res_ready,
        output prod_ready, res_valid, result, overflow, busy
    );
endinterface

// File: rtl/booth_mac_accumulator.sv
// rtl/booth_mac_accumulator.sv - saturating MAC reduction of a programmed number of products
module booth_mac_accumulator #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int LEN_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    booth_mac_accumulator_if.slave     bus
);
    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]           state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] result_q;
    logic [LEN_WIDTH-1:0] count;
    logic                 signed_q;
    logic                 overflow_q;

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] sat_acc;
    logic                 sat_hit;

    // One extra bit of headroom lets both signed and unsigned overflow be seen from the sum.
    always_comb begin
        prod_ext = {{(ACC_WIDTH-PW){signed_q & bus.product[PW-1]}}, bus.product};
        sum      = {signed_q & acc[ACC_WIDTH-1], acc}
                 + {signed_q & prod_ext[ACC_WIDTH-1], prod_ext};
        sat_hit  = 1'b0;
        sat_acc  = sum[ACC_WIDTH-1:0];
        if (signed_q) begin
            if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
                sat_hit = 1'b1;
                sat_acc = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else if (sum[ACC_WIDTH]) begin
            sat_hit = 1'b1;
            sat_acc = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            count      <= '0;
            result_q   <= '0;
            signed_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        signed_q   <= bus.signed_mode;
                        acc        <= '0;
                        overflow_q <= 1'b0;
                        if (bus.len == '0) begin
                            result_q <= '0;
                            state    <= S_DONE;
                        end else begin
                            count <= bus.len;
                            state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (bus.prod_valid) begin
                        acc   <= sat_acc;
                        count <= count - 1'b1;
                        if (sat_hit) begin
                            overflow_q <= 1'b1;
                        end
                        // last beat publishes the updated sum directly
                        if (count == LEN_WIDTH'(1)) begin
                            result_q <= sat_acc;
                            state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.prod_ready = (state == S_ACCUM);
    assign bus.res_valid  = (state == S_DONE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.result     = result_q;
    assign bus.overflow   = overflow_q;
endmodule
